// File: rtl/multicycle_ctrl_gen2.sv
// Multicycle MIPS-subset control unit: state register, combinational control decode
// and a retired-instruction counter.
module multicycle_ctrl_gen2 #(
  parameter int unsigned ALU_OP_W     = 3,
  parameter int unsigned CNT_W        = 16,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                zero_flag,
  input  logic [31:0]         instruction,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                write_reg_sel,
  output logic                mem_to_reg,
  output logic                write_data_sel,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic [CNT_W-1:0]    retired_count
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnJr  = 6'b001000;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    StIf, StId, StJump, StJal, StBranch, StExec, StWb,
    StMemAddr, StSw, StLwRd, StLwWb, StJr, StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       opcode, funct;
  logic             r_legal, retire;
  logic [2:0]       exec_alu, alu_op3;
  logic             unused_instr;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_instr  = ^instruction[25:6];
  assign alu_op        = ALU_OP_W'(alu_op3);
  assign retired_count = cnt_q;

  // R-type funct legality and the ALU operation used in EXEC.
  always_comb begin
    r_legal  = 1'b1;
    exec_alu = AluAdd;
    if (opcode == OpRtype) begin
      case (funct)
        FnAdd:   exec_alu = AluAdd;
        FnSub:   exec_alu = AluSub;
        FnAnd:   exec_alu = AluAnd;
        FnOr:    exec_alu = AluOr;
        FnSlt:   exec_alu = AluSlt;
        FnJr:    exec_alu = AluAdd;
        default: r_legal  = 1'b0;
      endcase
    end else begin
      case (opcode)
        OpAndi:  exec_alu = AluAnd;
        OpOri:   exec_alu = AluOr;
        OpSlti:  exec_alu = AluSlt;
        default: exec_alu = AluAdd;
      endcase
    end
  end

  // Next-state, control decode and retirement detection.
  always_comb begin
    state_d        = state_q;
    pc_write       = 1'b0;
    iord           = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ir_write       = 1'b0;
    reg_dst        = 1'b0;
    write_reg_sel  = 1'b0;
    mem_to_reg     = 1'b0;
    write_data_sel = 1'b0;
    reg_write      = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    pc_src         = 2'b00;
    alu_op3        = 3'b000;
    halted         = 1'b0;
    retire         = 1'b0;
    unique case (state_q)
      StIf: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op3   = AluAdd;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StId;
      end
      StId: begin
        alu_src_b = 2'b11;
        alu_op3   = AluAdd;
        case (opcode)
          OpRtype: begin
            if (!r_legal)           state_d = ILLEGAL_HALT ? StHalt : StIf;
            else if (funct == FnJr) state_d = StJr;
            else                    state_d = StExec;
          end
          OpJ:                            state_d = StJump;
          OpJal:                          state_d = StJal;
          OpBeq, OpBne:                   state_d = StBranch;
          OpAddi, OpAndi, OpOri, OpSlti:  state_d = StExec;
          OpLw, OpSw:                     state_d = StMemAddr;
          default:                        state_d = ILLEGAL_HALT ? StHalt : StIf;
        endcase
      end
      StJump: begin
        pc_src   = 2'b01;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = StIf;
      end
      StJal: begin
        pc_src         = 2'b01;
        pc_write       = 1'b1;
        write_reg_sel  = 1'b1;
        write_data_sel = 1'b1;
        reg_write      = 1'b1;
        retire         = 1'b1;
        state_d        = StIf;
      end
      StJr: begin
        pc_src   = 2'b11;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = StIf;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op3   = AluSub;
        pc_src    = 2'b10;
        // beq writes the PC on zero, bne on non-zero.
        pc_write  = (opcode == OpBne) ? !zero_flag : zero_flag;
        retire    = 1'b1;
        state_d   = StIf;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_src_b = (opcode == OpRtype) ? 2'b00 : 2'b10;
        alu_op3   = exec_alu;
        state_d   = StWb;
      end
      StWb: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OpRtype);
        retire    = 1'b1;
        state_d   = StIf;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op3   = AluAdd;
        state_d   = (opcode == OpLw) ? StLwRd : StSw;
      end
      StSw: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StIf;
        end
      end
      StLwRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = StLwWb;
      end
      StLwWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = StIf;
      end
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
      default: state_d = StIf;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_gen2.sv
// Randomized bench: two controller instances (default and NOP-on-illegal, 4-bit count,
// 4-bit alu_op) checked cycle by cycle against per-instruction control tables.
module tb_multicycle_ctrl_gen2;

  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, write_reg_sel;
    logic       mem_to_reg, write_data_sel, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic       halted;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, zero_flag, mem_ready;
  logic [31:0] instruction;

  logic pc_write_a, iord_a, mem_read_a, mem_write_a, ir_write_a, reg_dst_a, write_reg_sel_a;
  logic mem_to_reg_a, write_data_sel_a, reg_write_a, alu_src_a_a, halted_a;
  logic [1:0]  alu_src_b_a, pc_src_a;
  logic [2:0]  alu_op_a;
  logic [15:0] retired_count_a;

  logic pc_write_b, iord_b, mem_read_b, mem_write_b, ir_write_b, reg_dst_b, write_reg_sel_b;
  logic mem_to_reg_b, write_data_sel_b, reg_write_b, alu_src_a_b, halted_b;
  logic [1:0]  alu_src_b_b, pc_src_b;
  logic [3:0]  alu_op_b;
  logic [3:0]  retired_count_b;

  ctl_t act_a, act_b;
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_gen2 u_dut_a (
    .clk(clk), .rst(rst_a), .zero_flag(zero_flag), .instruction(instruction),
    .mem_ready(mem_ready), .pc_write(pc_write_a), .iord(iord_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .ir_write(ir_write_a), .reg_dst(reg_dst_a),
    .write_reg_sel(write_reg_sel_a), .mem_to_reg(mem_to_reg_a),
    .write_data_sel(write_data_sel_a), .reg_write(reg_write_a), .alu_src_a(alu_src_a_a),
    .alu_src_b(alu_src_b_a), .pc_src(pc_src_a), .alu_op(alu_op_a), .halted(halted_a),
    .retired_count(retired_count_a)
  );

  multicycle_ctrl_gen2 #(.ALU_OP_W(4), .CNT_W(4), .ILLEGAL_HALT(1'b0)) u_dut_b (
    .clk(clk), .rst(rst_b), .zero_flag(zero_flag), .instruction(instruction),
    .mem_ready(mem_ready), .pc_write(pc_write_b), .iord(iord_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .ir_write(ir_write_b), .reg_dst(reg_dst_b),
    .write_reg_sel(write_reg_sel_b), .mem_to_reg(mem_to_reg_b),
    .write_data_sel(write_data_sel_b), .reg_write(reg_write_b), .alu_src_a(alu_src_a_b),
    .alu_src_b(alu_src_b_b), .pc_src(pc_src_b), .alu_op(alu_op_b), .halted(halted_b),
    .retired_count(retired_count_b)
  );

  assign act_a = {pc_write_a, iord_a, mem_read_a, mem_write_a, ir_write_a, reg_dst_a,
                  write_reg_sel_a, mem_to_reg_a, write_data_sel_a, reg_write_a, alu_src_a_a,
                  alu_src_b_a, pc_src_a, alu_op_a, halted_a};
  assign act_b = {pc_write_b, iord_b, mem_read_b, mem_write_b, ir_write_b, reg_dst_b,
                  write_reg_sel_b, mem_to_reg_b, write_data_sel_b, reg_write_b, alu_src_a_b,
                  alu_src_b_b, pc_src_b, alu_op_b[2:0], halted_b};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control words per phase of an instruction.
  function automatic ctl_t v_if(input logic mr);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
    c.ir_write = mr;   c.pc_write  = mr;
    return c;
  endfunction

  function automatic ctl_t v_id();
    ctl_t c = '0;
    c.alu_src_b = 2'b11; c.alu_op = 3'b010;
    return c;
  endfunction

  function automatic ctl_t v_exec(input logic [31:0] ins);
    ctl_t c = '0;
    c.alu_src_a = 1'b1;
    if (ins[31:26] == 6'h00) begin
      c.alu_src_b = 2'b00;
      case (ins[5:0])
        6'b100010: c.alu_op = 3'b110;
        6'b100100: c.alu_op = 3'b000;
        6'b100101: c.alu_op = 3'b001;
        6'b101010: c.alu_op = 3'b111;
        default:   c.alu_op = 3'b010;
      endcase
    end else begin
      c.alu_src_b = 2'b10;
      case (ins[31:26])
        6'b001100: c.alu_op = 3'b000;
        6'b001101: c.alu_op = 3'b001;
        6'b001010: c.alu_op = 3'b111;
        default:   c.alu_op = 3'b010;
      endcase
    end
    return c;
  endfunction

  task automatic step_check(input ctl_t ea, input ctl_t eb, input logic mr);
    @(negedge clk);
    mem_ready = mr;
    #1;
    check_eq("ctl_a", {13'b0, act_a}, {13'b0, ea});
    check_eq("ctl_b", {13'b0, act_b}, {13'b0, eb});
    check_eq("aluop_b", {28'b0, alu_op_b}, {29'b0, eb.alu_op});
  endtask

  task automatic check_counts();
    check_eq("cnt_a", {16'b0, retired_count_a}, model_cnt & 32'hffff);
    check_eq("cnt_b", {28'b0, retired_count_b}, model_cnt & 32'hf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    model_cnt = 0;
  endtask

  // Runs one legal instruction; w_if / w_mem are the not-ready cycles in fetch / memory.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int w_if,
                           input int w_mem);
    ctl_t eq[$];
    logic mq[$];
    ctl_t c;
    logic [5:0] op = ins[31:26];
    instruction = ins;
    zero_flag   = z;
    for (int i = 0; i < w_if; i++) begin eq.push_back(v_if(1'b0)); mq.push_back(1'b0); end
    eq.push_back(v_if(1'b1)); mq.push_back(1'b1);
    eq.push_back(v_id());     mq.push_back(1'($urandom));
    c = '0;
    case (op)
      6'h00: begin
        if (ins[5:0] == 6'b001000) begin
          c.pc_src = 2'b11; c.pc_write = 1'b1; eq.push_back(c);
        end else begin
          eq.push_back(v_exec(ins));
          c.reg_write = 1'b1; c.reg_dst = 1'b1; eq.push_back(c);
        end
      end
      6'h02: begin c.pc_src = 2'b01; c.pc_write = 1'b1; eq.push_back(c); end
      6'h03: begin
        c.pc_src = 2'b01; c.pc_write = 1'b1; c.write_reg_sel = 1'b1;
        c.write_data_sel = 1'b1; c.reg_write = 1'b1; eq.push_back(c);
      end
      6'h04, 6'h05: begin
        c.alu_src_a = 1'b1; c.alu_op = 3'b110; c.pc_src = 2'b10;
        c.pc_write = (op == 6'h04) ? z : !z; eq.push_back(c);
      end
      6'h08, 6'h0a, 6'h0c, 6'h0d: begin
        eq.push_back(v_exec(ins));
        c.reg_write = 1'b1; eq.push_back(c);
      end
      default: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b010; eq.push_back(c);
        c = '0; c.iord = 1'b1;
        if (op == 6'h23) c.mem_read = 1'b1; else c.mem_write = 1'b1;
        for (int i = 0; i <= w_mem; i++) eq.push_back(c);
        if (op == 6'h23) begin
          c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; eq.push_back(c);
        end
      end
    endcase
    while (mq.size() < eq.size()) mq.push_back(1'($urandom));
    // Memory-phase ready pattern: w_mem low cycles then high.
    if (op == 6'h23 || op == 6'h2b) begin
      for (int i = 0; i <= w_mem; i++) mq[w_if + 3 + i] = (i == w_mem);
    end
    for (int k = 0; k < eq.size(); k++) begin
      step_check(eq[k], eq[k], mq[k]);
      if (k == 0) check_counts();
    end
    model_cnt++;
  endtask

  // Illegal opcode: instance a halts, instance b refetches as a NOP; then reset.
  task automatic run_illegal(input logic [31:0] ins);
    ctl_t halt_v = '0;
    int   saved = model_cnt;
    halt_v.halted = 1'b1;
    instruction = ins;
    zero_flag   = 1'($urandom);
    for (int k = 0; k < 14; k++) begin
      step_check((k == 0) ? v_if(1'b1) : (k == 1) ? v_id() : halt_v,
                 (k % 2 == 0) ? v_if(1'b1) : v_id(), 1'b1);
    end
    model_cnt = saved;
    check_counts();
    do_reset();
    #1;
    check_eq("rst_halt", {13'b0, act_a}, {13'b0, v_if(1'b0)});
    check_counts();
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] ins = $urandom;
    case ($urandom_range(0, 12))
      0:  begin ins[31:26] = 6'h00; ins[5:0] = 6'b100000; end
      1:  begin ins[31:26] = 6'h00; ins[5:0] = 6'b100010; end
      2:  begin ins[31:26] = 6'h00; ins[5:0] = 6'b100100; end
      3:  begin ins[31:26] = 6'h00; ins[5:0] = 6'b100101; end
      4:  begin ins[31:26] = 6'h00; ins[5:0] = 6'b101010; end
      5:  begin ins[31:26] = 6'h00; ins[5:0] = 6'b001000; end
      6:  ins[31:26] = 6'h02;
      7:  ins[31:26] = 6'h03;
      8:  ins[31:26] = 6'h04;
      9:  ins[31:26] = 6'h05;
      10: begin
        case ($urandom_range(0, 3))
          0: ins[31:26] = 6'h08;
          1: ins[31:26] = 6'h0a;
          2: ins[31:26] = 6'h0c;
          default: ins[31:26] = 6'h0d;
        endcase
      end
      11: ins[31:26] = 6'h23;
      default: ins[31:26] = 6'h2b;
    endcase
    return ins;
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] ins = $urandom;
    logic [5:0]  op;
    logic [5:0]  fn;
    if ($urandom_range(0, 1) == 0) begin
      do op = 6'($urandom); while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                               6'h0a, 6'h0c, 6'h0d, 6'h23, 6'h2b});
      ins[31:26] = op;
    end else begin
      do fn = 6'($urandom); while (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                               6'b101010, 6'b001000});
      ins[31:26] = 6'h00;
      ins[5:0]   = fn;
    end
    return ins;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    rst_a = 1'b1; rst_b = 1'b1; zero_flag = 1'b0; mem_ready = 1'b0; instruction = '0;
    do_reset();
    // Reset state: IF decode, pc_write/ir_write following mem_ready.
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check_eq("rst_if0", {13'b0, act_a}, {13'b0, v_if(1'b0)});
    check_counts();
    mem_ready = 1'b1; #1;
    check_eq("rst_if1", {13'b0, act_a}, {13'b0, v_if(1'b1)});
    #1 mem_ready = 1'b0;

    // Directed: add, bne/beq with zero set, lw with three memory waits.
    ins = $urandom; ins[31:26] = 6'h00; ins[5:0] = 6'b100000;
    run_instr(ins, 1'b0, 0, 0);
    ins = $urandom; ins[31:26] = 6'h05; run_instr(ins, 1'b1, 0, 0);
    ins = $urandom; ins[31:26] = 6'h04; run_instr(ins, 1'b1, 0, 0);
    ins = $urandom; ins[31:26] = 6'h23; run_instr(ins, 1'b0, 0, 3);
    ins = $urandom; ins[31:26] = 6'h2b; run_instr(ins, 1'b0, 1, 2);

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(rand_legal(), 1'($urandom), 0, 0);
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check_eq("wrap_b", {28'b0, retired_count_b}, 32'd1);
    check_counts();

    // Directed illegal opcode 111111.
    ins = $urandom; ins[31:26] = 6'b111111;
    run_illegal(ins);

    // Reset while a store is waiting on memory.
    run_instr(rand_legal(), 1'b0, 0, 0);
    begin
      ctl_t sw_v = '0;
      ctl_t ma_v = '0;
      sw_v.iord = 1'b1; sw_v.mem_write = 1'b1;
      ma_v.alu_src_a = 1'b1; ma_v.alu_src_b = 2'b10; ma_v.alu_op = 3'b010;
      ins = $urandom; ins[31:26] = 6'h2b;
      instruction = ins;
      step_check(v_if(1'b1), v_if(1'b1), 1'b1);
      step_check(v_id(), v_id(), 1'b0);
      step_check(ma_v, ma_v, 1'b0);
      step_check(sw_v, sw_v, 1'b0);
      step_check(sw_v, sw_v, 1'b0);
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; mem_ready = 1'b1; #1;
      model_cnt = 0;
      check_eq("swrst_ctl", {13'b0, act_a}, {13'b0, v_if(1'b1)});
      check_eq("swrst_mw", {31'b0, mem_write_a}, 32'd0);
      check_counts();
      #1 mem_ready = 1'b0;
    end

    // Randomized stream with occasional illegal instructions.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) run_illegal(rand_illegal());
      else run_instr(rand_legal(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check_counts();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_gen2.md
MULTICYCLE_CTRL_GEN2 -- requirements
Module: multicycle_ctrl_gen2

Interface
REQ-001 Parameter ALU_OP_W, default 3: width of alu_op; legal range 3..8; codes are zero-extended.
REQ-002 Parameter CNT_W, default 16: width of retired_count.
REQ-003 Parameter ILLEGAL_HALT, default 1: 1 means an illegal opcode or funct enters HALT; 0 means it returns to IF as a NOP.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 zero_flag  in  1  ALU zero result in the current cycle.
REQ-007 instruction  in  32  IR contents; opcode is [31:26], funct is [5:0].
REQ-008 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-009 pc_write, iord, mem_read, mem_write, ir_write, reg_dst, write_reg_sel, mem_to_reg, write_data_sel, reg_write, alu_src_a  out  1 each  datapath controls.
REQ-010 alu_src_b  out  2  ALU B-operand select: 00 reg, 01 const 4, 10 sign-ext imm, 11 shifted imm.
REQ-011 pc_src  out  2  PC source: 00 ALU, 01 jump target, 10 ALUOut, 11 register rs.
REQ-012 alu_op  out  ALU_OP_W  ALU operation: and 000, or 001, add 010, sub 110, slt 111.
REQ-013 halted  out  1  high while in HALT.
REQ-014 retired_count  out  CNT_W  count of completed instructions.

Function
REQ-015 Outputs are a combinational decode of the present state, instruction, zero_flag and mem_ready; every control is 0 unless a state below drives it.
REQ-016 States: IF, ID, JUMP, JAL, BRANCH, EXEC, WB, MEM_ADDR, SW, LW_RD, LW_WB, JR, HALT.
REQ-017 IF: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add; ir_write, pc_write and the move to ID occur only when mem_ready=1; otherwise the block holds in IF.
REQ-018 ID: alu_src_a=0, alu_src_b=11, alu_op=add. Next state by opcode: 000000 -> EXEC, or JR if funct=001000; 000010 -> JUMP; 000011 -> JAL; 000100/000101 -> BRANCH; 001000/001100/001101/001010 (addi/andi/ori/slti) -> EXEC; 100011/101011 -> MEM_ADDR; any other -> ILLEGAL.
REQ-019 ILLEGAL resolves to HALT if ILLEGAL_HALT=1, else to IF; an R-type funct outside {100000,100010,100100,100101,101010,001000} is also ILLEGAL.
REQ-020 JUMP: pc_src=01, pc_write=1, next IF.
REQ-021 JAL: pc_src=01, pc_write=1, write_reg_sel=1, write_data_sel=1, reg_write=1, next IF.
REQ-022 JR: pc_src=11, pc_write=1, next IF.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=10; pc_write=zero_flag for beq and pc_write=!zero_flag for bne; next IF.
REQ-024 EXEC: alu_src_a=1. R-type uses alu_src_b=00 with alu_op from funct (add, sub, and, or, slt). I-type uses alu_src_b=10 with addi->add, andi->and, ori->or, slti->slt. Next WB.
REQ-025 WB: reg_write=1; reg_dst=1 for R-type, 0 for I-type; next IF.
REQ-026 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add; next LW_RD for lw, SW for sw.
REQ-027 SW: iord=1, mem_write=1; holds until mem_ready=1, then IF.
REQ-028 LW_RD: iord=1, mem_read=1; holds until mem_ready=1, then LW_WB.
REQ-029 LW_WB: mem_to_reg=1, reg_write=1, reg_dst=0; next IF.
REQ-030 HALT: all controls 0, halted=1; remains in HALT until rst.
REQ-031 retired_count increments by 1, modulo 2^CNT_W, on every transition into IF from JUMP, JAL, JR, BRANCH (taken or not), WB, SW or LW_WB; illegal NOPs are not counted.
REQ-032 Latency in cycles with mem_ready always 1: J/JAL/JR/beq/bne 3, R/I ALU 4, sw 4, lw 5; each wait cycle adds 1.

Reset
REQ-033 rst=1 at a clock edge forces IF and retired_count=0, overriding any state including HALT and mid-wait SW/LW_RD.
REQ-034 After reset the outputs equal the IF decode: mem_read=1, alu_src_b=01, alu_op=010, and pc_write/ir_write equal mem_ready.

Verification
REQ-035 Reset, then add (funct 100000) with mem_ready=1 -> state path IF,ID,EXEC,WB; EXEC alu_op=010, WB reg_write=1, reg_dst=1; retired_count=1.
REQ-036 bne with zero_flag=1 -> pc_write=0 in BRANCH; beq with zero_flag=1 -> pc_write=1, pc_src=10; both retire.
REQ-037 lw with mem_ready low for 3 cycles in LW_RD -> mem_read and iord held high 3 cycles; LW_WB one cycle later; total latency 8 cycles.
REQ-038 Opcode 111111 with ILLEGAL_HALT=1 -> halted=1 and all controls 0 for 10+ cycles; rst -> IF, count 0. With ILLEGAL_HALT=0 -> IF after ID, count unchanged.
REQ-039 CNT_W=4: retire 17 instructions -> retired_count wraps to 1.
REQ-040 Assert rst during SW wait -> next cycle in IF, mem_write=0, retired_count=0.
